level_classifier: RTL and testbench

- Level-class decoder inside the CABAC rate estimator used by RDOQ.
- On a start pulse it captures one absolute coefficient level (uiAbsLevel) and the current base level (baseLevel).
- It classifies the level as ZERO, ONE, TWO or BASEPLUS and produces the residual symbol that the downstream bin-cost lookup consumes.
- Results are registered; done pulses for one cycle.

---
 rtl/level_classifier_pkg.sv | 25 ++
 rtl/level_classifier_decode.sv | 53 +++++
 rtl/level_classifier.sv | 77 +++++++
 tb/tb_level_classifier.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/level_classifier_pkg.sv
// Shared types for the CABAC level-class decoder: class encoding, FSM state
// and default widths.
package level_classifier_pkg;

  localparam int LEVEL_W = 16;
  localparam int BASE_W  = 8;

  typedef enum logic [1:0] {
    LC_ZERO     = 2'd0,
    LC_ONE      = 2'd1,
    LC_TWO      = 2'd2,
    LC_BASEPLUS = 2'd3
  } level_case_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } lc_state_e;

  typedef struct packed {
    level_case_e        level_case;
    logic [LEVEL_W-1:0] symbol;
  } lc_result_t;

endpackage

// File: rtl/level_classifier_decode.sv
// Combinational level classification and residual-symbol arithmetic.
// The symbol ceiling is applied only when LC_SYMBOL_CLAMP_EN is defined.
module level_classifier_decode
  import level_classifier_pkg::*;
#(
  parameter int                 LEVEL_W = level_classifier_pkg::LEVEL_W,
  parameter int                 BASE_W  = level_classifier_pkg::BASE_W,
  parameter logic [LEVEL_W-1:0] SYM_MAX = 16'hFFFF
) (
  input  logic [LEVEL_W-1:0] abs_level,
  input  logic [BASE_W-1:0]  base_level,
  output level_case_e        level_case,
  output logic [LEVEL_W-1:0] symbol
);

`ifdef LC_SYMBOL_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [LEVEL_W-1:0] ONE_L = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] TWO_L = LEVEL_W'(2);

  logic [LEVEL_W-1:0] base_ext;
  logic [LEVEL_W-1:0] raw_sym;

  // baseLevel is never wider than the level, so this cast only zero-extends.
  assign base_ext = LEVEL_W'(base_level);

  // Priority order matters: zero wins even over baseLevel==0, and the escape
  // test precedes ONE so that baseLevel==1 pushes level 1 into BASEPLUS.
  always_comb begin
    level_case = LC_ZERO;
    raw_sym    = '0;
    if (abs_level == '0) begin
      level_case = LC_ZERO;
      raw_sym    = '0;
    end else if (abs_level >= base_ext) begin
      level_case = LC_BASEPLUS;
      raw_sym    = abs_level - base_ext;
    end else if (abs_level == ONE_L) begin
      level_case = LC_ONE;
      raw_sym    = '0;
    end else begin
      level_case = LC_TWO;
      raw_sym    = abs_level - TWO_L;
    end
  end

  assign symbol = (CLAMP_EN && (raw_sym > SYM_MAX)) ? SYM_MAX : raw_sym;

endmodule

// File: rtl/level_classifier.sv
// Level-class decoder top: registers one classification per start pulse.
// Optional symbol saturation is compiled in with LC_SYMBOL_CLAMP_EN.
module level_classifier
  import level_classifier_pkg::*;
#(
  parameter int                 LEVEL_W = level_classifier_pkg::LEVEL_W,
  parameter int                 BASE_W  = level_classifier_pkg::BASE_W,
  parameter logic [LEVEL_W-1:0] SYM_MAX = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEVEL_W-1:0] uiAbsLevel,
  input  logic [BASE_W-1:0]  baseLevel,
  output level_case_e        level_case,
  output logic [LEVEL_W-1:0] symbol,
  output logic               done,
  output lc_state_e          state_dbg
);

  // Handshake: start is a request with no back-pressure; inputs are taken on
  // every clk edge where start=1, and done is high for the one cycle after
  // that edge carrying that request's result. Consecutive starts stream.

  level_case_e        dec_case;
  logic [LEVEL_W-1:0] dec_symbol;
  lc_state_e          state;

  level_classifier_decode #(
    .LEVEL_W (LEVEL_W),
    .BASE_W  (BASE_W),
    .SYM_MAX (SYM_MAX)
  ) u_decode (
    .abs_level  (uiAbsLevel),
    .base_level (baseLevel),
    .level_case (dec_case),
    .symbol     (dec_symbol)
  );

  // rst_n keeps its historical name but is an active-high reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      level_case <= LC_ZERO;
      symbol     <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RESULT;
            level_case <= dec_case;
            symbol     <= dec_symbol;
            done       <= 1'b1;
          end
        end
        ST_RESULT: begin
          if (start) begin
            level_case <= dec_case;
            symbol     <= dec_symbol;
            done       <= 1'b1;
          end else begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_level_classifier.sv
// Directed-vector bench for level_classifier: classification table plus
// reset, back-to-back and hold sequences.
module tb_level_classifier;
  import level_classifier_pkg::*;

  localparam int LW = 16;
  localparam int BW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] ui_abs_level;
  logic [BW-1:0] base_level;
  level_case_e   level_case;
  logic [LW-1:0] symbol;
  logic          done;
  lc_state_e     state_dbg;

  int n_checks;
  int n_errors;

  level_classifier #(
    .LEVEL_W (LW),
    .BASE_W  (BW),
    .SYM_MAX (16'd100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .uiAbsLevel (ui_abs_level),
    .baseLevel  (base_level),
    .level_case (level_case),
    .symbol     (symbol),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] lvl;
    logic [BW-1:0] base;
    logic [1:0]    exp_case;
    logic [LW-1:0] exp_sym;
  } vec_t;

  vec_t vecs[$];
  logic [LW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [LW-1:0] lvl, input logic [BW-1:0] base,
                         input logic [1:0] c, input logic [LW-1:0] s);
    vec_t v;
    v.lvl = lvl; v.base = base; v.exp_case = c; v.exp_sym = s;
    vecs.push_back(v);
  endtask

  // driver: one start pulse, then result check and one hold check
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    start = 1'b1; ui_abs_level = v.lvl; base_level = v.base;
    @(negedge clk);
    start = 1'b0;
    ui_abs_level = LW'($urandom_range(0, 65535));
    base_level   = BW'($urandom_range(0, 255));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_RESULT));
    check({tag, "_case"}, 32'(level_case), 32'(v.exp_case));
    check({tag, "_sym"}, 32'(symbol), 32'(v.exp_sym));
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_hold_case"}, 32'(level_case), 32'(v.exp_case));
    check({tag, "_hold_sym"}, 32'(symbol), 32'(v.exp_sym));
  endtask

  initial begin
    logic [LW-1:0] big_sym;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1; start = 1'b0; ui_abs_level = '0; base_level = '0;

`ifdef LC_SYMBOL_CLAMP_EN
    big_sym = 16'd100;
`else
    big_sym = 16'hFFFF;
`endif
    add_vec(16'd0,     8'd3,   2'd0, 16'd0);
    add_vec(16'd1,     8'd3,   2'd1, 16'd0);
    add_vec(16'd2,     8'd3,   2'd2, 16'd0);
    add_vec(16'd7,     8'd3,   2'd3, 16'd4);
    add_vec(16'd3,     8'd3,   2'd3, 16'd0);
    add_vec(16'd1,     8'd1,   2'd3, 16'd0);
    add_vec(16'd2,     8'd1,   2'd3, 16'd1);
    add_vec(16'd2,     8'd2,   2'd3, 16'd0);
    add_vec(16'd5,     8'd8,   2'd2, 16'd3);
    add_vec(16'd0,     8'd0,   2'd0, 16'd0);
    add_vec(16'd1,     8'd0,   2'd3, 16'd1);
    add_vec(16'd254,   8'd255, 2'd2, 16'd252);
    add_vec(16'd255,   8'd255, 2'd3, 16'd0);
    add_vec(16'd300,   8'd200, 2'd3, 16'd100);
    add_vec(16'hFFFF,  8'd0,   2'd3, big_sym);

    // reset held two cycles
    repeat (2) @(negedge clk);
    check("rst_case", 32'(level_case), 32'd0);
    check("rst_sym", 32'(symbol), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // back-to-back starts: levels 0,1,9 at base 3
    exp_q = {16'd0, 16'd0, 16'd6};
    @(negedge clk);
    start = 1'b1; base_level = 8'd3; ui_abs_level = 16'd0;
    @(negedge clk);
    check("b2b0_done", 32'(done), 32'd1);
    check("b2b0_case", 32'(level_case), 32'd0);
    check("b2b0_sym", 32'(symbol), 32'(exp_q.pop_front()));
    ui_abs_level = 16'd1;
    @(negedge clk);
    check("b2b1_done", 32'(done), 32'd1);
    check("b2b1_case", 32'(level_case), 32'd1);
    check("b2b1_sym", 32'(symbol), 32'(exp_q.pop_front()));
    ui_abs_level = 16'd9;
    @(negedge clk);
    start = 1'b0;
    check("b2b2_done", 32'(done), 32'd1);
    check("b2b2_case", 32'(level_case), 32'd3);
    check("b2b2_sym", 32'(symbol), 32'(exp_q.pop_front()));
    ui_abs_level = 16'd2; base_level = 8'd9;
    repeat (2) begin
      @(negedge clk);
      check("b2b_hold_done", 32'(done), 32'd0);
      check("b2b_hold_case", 32'(level_case), 32'd3);
      check("b2b_hold_sym", 32'(symbol), 32'd6);
    end

    // asynchronous reset between edges clears a held result
    #2 rst_n = 1'b1;
    #1;
    check("async_rst_case", 32'(level_case), 32'd0);
    check("async_rst_sym", 32'(symbol), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // asynchronous reset while a result is pending discards it
    start = 1'b1; ui_abs_level = 16'd7; base_level = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("pend_done", 32'(done), 32'd1);
    check("pend_sym", 32'(symbol), 32'd4);
    #1 rst_n = 1'b1;
    #1;
    check("pend_rst_done", 32'(done), 32'd0);
    check("pend_rst_case", 32'(level_case), 32'd0);
    check("pend_rst_sym", 32'(symbol), 32'd0);
    check("pend_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
